// File: rtl/exibe_jogadas_pkg.sv
// Shared definitions for the play presenter.
// State codes double as the debug display value.
package exibe_jogadas_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    CARREGA = 4'd1,
    ACESO   = 4'd2,
    APAGADO = 4'd3,
    FIM     = 4'd4
  } estado_t;

  localparam int ON_CYCLES_DEF  = 500;
  localparam int OFF_CYCLES_DEF = 250;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/exibe_jogadas_contador.sv
// Modulo-M counter: wraps to 0 after reaching i_max.
// o_fim flags the terminal count.
module contador_m #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_max,
  output logic         o_fim
);

  logic [W-1:0] r_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_en) begin
      if (r_q == i_max) r_q <= '0;
      else              r_q <= r_q + W'(1);
    end
  end

  assign o_fim = (r_q == i_max);

endmodule

// File: rtl/exibe_jogadas.sv
// Memory game sequence presenter: lights each stored
// play for ON_CYCLES, dark for OFF_CYCLES, then pulses pronto.
module exibe_jogadas
  import exibe_jogadas_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter int ADDR_W     = 4,
  parameter int ON_CYCLES  = ON_CYCLES_DEF,
  parameter int OFF_CYCLES = OFF_CYCLES_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              cancelar,
  input  logic [ADDR_W-1:0] limite,
  input  logic [DATA_W-1:0] dado,
  output logic [ADDR_W-1:0] endereco,
  output logic [DATA_W-1:0] leds,
  output logic              ocupado,
  output logic              pronto,
  output logic [3:0]        db_estado
);

  localparam int MAXC = max_int(ON_CYCLES, OFF_CYCLES);
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  estado_t           r_estado;
  estado_t           w_next;
  logic [ADDR_W-1:0] r_endereco;
  logic [ADDR_W-1:0] r_limite;
  logic [DATA_W-1:0] r_leds;
  logic              r_pronto;

  logic              w_clr;
  logic              w_en;
  logic              w_fim;
  logic              w_abort;
  logic              w_ultimo;
  logic [TW-1:0]     w_max;

  assign w_abort  = cancelar && (r_estado != IDLE);
  assign w_ultimo = (r_endereco == r_limite);
  assign w_max    = (r_estado == ACESO) ? TW'(ON_CYCLES - 1)
                                        : TW'(OFF_CYCLES - 1);

  contador_m #(
    .W (TW)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .i_clr (w_clr),
    .i_en  (w_en),
    .i_max (w_max),
    .o_fim (w_fim)
  );

  always_comb begin
    w_next = r_estado;
    w_clr  = 1'b0;
    w_en   = 1'b0;
    if (w_abort) begin
      w_next = IDLE;
      w_clr  = 1'b1;
    end else begin
      unique case (r_estado)
        IDLE: begin
          w_clr = 1'b1;
          if (iniciar) w_next = CARREGA;
        end
        CARREGA: begin
          w_clr  = 1'b1;
          w_next = ACESO;
        end
        ACESO: begin
          w_en = 1'b1;
          if (w_fim) w_next = APAGADO;
        end
        APAGADO: begin
          w_en = 1'b1;
          if (w_fim) w_next = w_ultimo ? FIM : CARREGA;
        end
        FIM:     w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado   <= IDLE;
      r_endereco <= '0;
      r_limite   <= '0;
      r_leds     <= '0;
      r_pronto   <= 1'b0;
    end else begin
      r_estado <= w_next;
      r_pronto <= (w_next == FIM);
      if (w_abort) begin
        r_leds     <= '0;
        r_endereco <= '0;
      end else if (r_estado == IDLE && iniciar) begin
        r_limite   <= limite;
        r_endereco <= '0;
      end else if (r_estado == CARREGA) begin
        r_leds <= dado;
      end else if (r_estado == ACESO && w_fim) begin
        r_leds <= '0;
      end else if (r_estado == APAGADO && w_fim && !w_ultimo) begin
        r_endereco <= r_endereco + ADDR_W'(1);
      end
    end
  end

  assign endereco  = r_endereco;
  assign leds      = r_leds;
  assign pronto    = r_pronto;
  assign ocupado   = (r_estado != IDLE);
  assign db_estado = r_estado;

endmodule

// File: doc/exibe_jogadas.md
# exibe_jogadas

Sequence presenter for the memory game: on a start pulse it reads the stored plays from address 0 up to the current round limit and shows each one on `leds` for a fixed on-time followed by an off-gap, then pulses `pronto`. It is the presentation side of the play protocol. The game datapath captures `chaves` from the player and compares them against memory; this block drives the same memory contents out to the player before each round. It sits beside the game datapath and shares the play memory's read port through `endereco`/`dado`.

## Interface
- `DATA_W`, default 4: play width, one-hot per LED.
- `ADDR_W`, default 4: memory address width; up to 16 plays.
- `ON_CYCLES`, default 500: cycles a play stays lit (0.5 s at 1 kHz). Must be ≥1.
- `OFF_CYCLES`, default 250: dark cycles after each play. Must be ≥1.
- `clock` in 1: rising-edge clock, 1 kHz in the system.
- `reset` in 1: asynchronous, active-low; clears all state.
- `iniciar` in 1: start request, sampled only in IDLE.
- `cancelar` in 1: synchronous abort.
- `limite` in ADDR_W: index of the last play to show; round r uses r-1.
- `dado` in DATA_W: memory read data, combinational from `endereco`.
- `endereco` out ADDR_W: memory read address, registered.
- `leds` out DATA_W: displayed play, registered.
- `ocupado` out 1: high in every state except IDLE.
- `pronto` out 1: one-cycle completion pulse.
- `db_estado` out 4: state code for the 7-seg debug display.

## Operation
- Reset values: state IDLE, `endereco`=0, `leds`=0, `pronto`=0, `ocupado`=0, timer=0, latched limit=0.
- IDLE (0):
  - `iniciar`=1: latch `limite`, set `endereco`=0, go to CARREGA.
  - Otherwise hold.
- CARREGA (1):
  - `leds`<=`dado`, timer<=0, go to ACESO.
  - The address was stable for the whole cycle, so `dado` is valid.
- ACESO (2):
  - Timer increments each cycle.
  - When timer = ON_CYCLES-1: `leds`<=0, timer<=0, go to APAGADO.
- APAGADO (3):
  - Timer increments each cycle.
  - When timer = OFF_CYCLES-1 and `endereco` = latched limit: go to FIM.
  - When timer = OFF_CYCLES-1 and `endereco` ≠ latched limit: `endereco`+1, go to CARREGA.
- FIM (4): `pronto`=1 for this cycle only, go to IDLE. `endereco` and `leds` hold their values (`leds` is already 0).
- `cancelar`=1 in any non-IDLE state:
  - Next state is IDLE, `leds`<=0, `endereco`<=0, no `pronto`.
  - Takes priority over timer expiry and over FIM.
- `iniciar` outside IDLE is ignored. `iniciar` and `cancelar` both high in IDLE: start wins, since cancel applies only outside IDLE.
- Changes to `limite` after the latch do not affect the current presentation.
- No address wrap: `limite`=2^ADDR_W-1 shows all 16 plays and stops at 15.
- `dado`=0 is displayed as all-dark for the full on-time; the timing is unchanged.

## Timing
- Per play: exactly 1 + ON_CYCLES + OFF_CYCLES cycles. `leds` is nonzero for exactly ON_CYCLES cycles.
- `iniciar` sampled at edge e0:
  - First play appears on `leds` after edge e0+1.
  - FIM is entered after edge e0 + n·(1+ON_CYCLES+OFF_CYCLES), where n = limite+1.
  - `pronto` is high during the cycle after that edge.
  - Back to IDLE on the following edge; a new start is accepted from that IDLE cycle onward.
- `endereco` changes only on the APAGADO→CARREGA edge, or goes to 0 on start, cancel or reset.
- Timer width: clog2(max(ON_CYCLES, OFF_CYCLES)) bits.
- All outputs are registered except `ocupado` and `db_estado`, which decode the state register.

## Structure
- Shared package holds:
  - state codes IDLE=0, CARREGA=1, ACESO=2, APAGADO=3, FIM=4, used by `db_estado` and the hex decoder;
  - default timing constants ON_CYCLES and OFF_CYCLES.
- One sub-module: `contador_m`, a modulo-M counter with clear, enable and a `fim` flag. It is instantiated once, with M selected per state.
- The FSM and the address register stay in the top level.

## Test plan
Parameters for all scenarios: ON_CYCLES=3, OFF_CYCLES=2.
- **Reset and idle:** drive `reset`=0 mid-cycle.
  - Outputs clear immediately: `leds`=0, `endereco`=0, `pronto`=0, `ocupado`=0, `db_estado`=0.
- **Round 1:** memory {0001, 0010, 0100}, `limite`=0, pulse `iniciar`.
  - `leds`=0001 for exactly 3 cycles, then 0 for 2 cycles.
  - `pronto` pulses once, 6 cycles after the `iniciar` edge.
  - `endereco` stays at 0.
- **Round 3:** `limite`=2.
  - `leds` shows 0001, 0010, 0100 in order, each for 3 cycles with 2-cycle gaps.
  - `endereco` steps 0→1→2.
  - `pronto` arrives 18 cycles after the start edge.
- **Cancel:** assert `cancelar` during the second ACESO of a `limite`=2 run.
  - Next cycle: IDLE, `leds`=0, `endereco`=0.
  - No `pronto` for the rest of the run.
- **Busy handling:**
  - Pulse `iniciar` and change `limite` mid-run: presentation continues unchanged with the latched limit.
  - Restart immediately after `pronto`: second run accepted with identical timing.
- **Full depth:** `limite`=15.
  - 16 plays shown, `endereco` ends at 15 with no wrap.
  - `pronto` at 96 cycles.
